menu_scheduler: RTL

//  Sequences the text-overlay menu: turns raw keypad codes into debounced press events and decides the next screen (MENU/TEXT1..3).

---
 rtl/menu_scheduler.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/menu_scheduler.sv
// Text-overlay menu sequencer: debounces keypad codes into press events and
// commits screen changes (and the overlay window config) only on vblnk rise.
module menu_scheduler #(
    parameter logic [3:0] KEY_NONE       = 4'h0,
    parameter logic [3:0] KEY_2          = 4'h2,
    parameter logic [3:0] KEY_3          = 4'h3,
    parameter logic [3:0] KEY_4          = 4'h4,
    parameter logic [3:0] KEY_ESC        = 4'hE,
    parameter int         DEBOUNCE_CYC   = 16,
    parameter int         TIMEOUT_FRAMES = 600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_i,
    input  logic        vblnk_i,
    output logic [1:0]  state_o,
    output logic [1:0]  select_text_o,
    output logic [10:0] pos_x_o,
    output logic [10:0] pos_y_o,
    output logic [10:0] text_w_o,
    output logic [10:0] text_h_o,
    output logic [1:0]  scale_o,
    output logic        state_chg_o,
    output logic        press_evt_o
);
    typedef enum logic [1:0] {S_MENU, S_TEXT1, S_TEXT2, S_TEXT3} scr_e;

    typedef struct packed {
        logic [10:0] px;
        logic [10:0] py;
        logic [10:0] w;
        logic [10:0] h;
        logic [1:0]  scale;
    } cfg_t;

    localparam int          CW      = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);
    localparam logic [9:0]  TO_LAST = (TIMEOUT_FRAMES == 0) ? 10'd0 : 10'(TIMEOUT_FRAMES - 1);

    function automatic cfg_t cfg_of(scr_e s);
        case (s)
            S_MENU:  cfg_of = '{11'd200, 11'd100, 11'd128, 11'd64,  2'd1};
            S_TEXT1: cfg_of = '{11'd200, 11'd200, 11'd512, 11'd128, 2'd0};
            S_TEXT2: cfg_of = '{11'd200, 11'd200, 11'd512, 11'd128, 2'd0};
            default: cfg_of = '{11'd100, 11'd100, 11'd512, 11'd128, 2'd0};
        endcase
    endfunction

    scr_e          state_q, state_d, pend_state_q, pend_state_d, tgt, new_state;
    cfg_t          cfg_q, cfg_d;
    logic [3:0]    key_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    frm_q, frm_d;
    logic          armed_q, armed_d, pend_valid_q, pend_valid_d, vblnk_q;
    logic          chg_q, chg_d, press_q;
    logic          stable, fire, valid, rise, timeout, commit;

    always_comb begin
        stable  = (key_i == key_q);
        cnt_d   = stable ? ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1) : '0;
        fire    = stable && (key_q != KEY_NONE) && (cnt_q == CNT_MAX) && armed_q;
        armed_d = armed_q;
        if (fire)
            armed_d = 1'b0;
        else if (stable && (key_q == KEY_NONE) && (cnt_q == CNT_MAX))
            armed_d = 1'b1;

        // Validity is judged against the committed screen, not the pending one.
        valid = 1'b0;
        tgt   = S_MENU;
        if (state_q == S_MENU) begin
            if (key_q == KEY_2)      begin valid = 1'b1; tgt = S_TEXT1; end
            else if (key_q == KEY_3) begin valid = 1'b1; tgt = S_TEXT2; end
            else if (key_q == KEY_4) begin valid = 1'b1; tgt = S_TEXT3; end
        end else if (key_q == KEY_ESC) begin
            valid = 1'b1;
        end

        rise      = vblnk_i & ~vblnk_q;
        timeout   = rise && (state_q != S_MENU) && !pend_valid_q &&
                    (TIMEOUT_FRAMES != 0) && (frm_q == TO_LAST);
        commit    = rise && (pend_valid_q || timeout);
        new_state = pend_valid_q ? pend_state_q : S_MENU;

        state_d = commit ? new_state : state_q;
        cfg_d   = commit ? cfg_of(new_state) : cfg_q;
        chg_d   = commit && (new_state != state_q);

        // A press landing in the rise cycle is queued for the next frame.
        pend_valid_d = commit ? 1'b0 : pend_valid_q;
        pend_state_d = pend_state_q;
        if (fire && valid) begin
            pend_valid_d = 1'b1;
            pend_state_d = tgt;
        end

        frm_d = frm_q;
        if (commit || fire)
            frm_d = '0;
        else if (rise && (state_q != S_MENU) && (frm_q != 10'h3FF))
            frm_d = frm_q + 10'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_MENU;
            cfg_q        <= cfg_of(S_MENU);
            pend_state_q <= S_MENU;
            pend_valid_q <= 1'b0;
            key_q        <= KEY_NONE;
            cnt_q        <= '0;
            armed_q      <= 1'b1;
            frm_q        <= '0;
            vblnk_q      <= 1'b0;
            chg_q        <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfg_q        <= cfg_d;
            pend_state_q <= pend_state_d;
            pend_valid_q <= pend_valid_d;
            key_q        <= key_i;
            cnt_q        <= cnt_d;
            armed_q      <= armed_d;
            frm_q        <= frm_d;
            vblnk_q      <= vblnk_i;
            chg_q        <= chg_d;
            press_q      <= fire;
        end
    end

    assign state_o       = state_q;
    assign select_text_o = state_q;
    assign pos_x_o       = cfg_q.px;
    assign pos_y_o       = cfg_q.py;
    assign text_w_o      = cfg_q.w;
    assign text_h_o      = cfg_q.h;
    assign scale_o       = cfg_q.scale;
    assign state_chg_o   = chg_q;
    assign press_evt_o   = press_q;
endmodule
